// File: rtl/rollover_counter.sv
// Programmable modulo-k cycle counter that drives the downstream clock divider's rollover input.
// A new modulus is accepted through a handshake and only takes effect on a wrap boundary.
module rollover_counter #(
    parameter int WIDTH     = 8,
    parameter int DEFAULT_K = 3
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_k_valid,
    input  logic [WIDTH-1:0] i_k,
    output logic             o_k_ready,
    output logic             o_k_err,
    output logic [WIDTH-1:0] o_count,
    output logic             o_roll_over
);

    localparam logic [WIDTH-1:0] K_RESET = WIDTH'(DEFAULT_K);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] k_active;
    logic [WIDTH-1:0] k_pending;
    logic             roll_over;
    logic             k_err;

    // Handshake: a modulus transfers on a rising edge where i_k_valid && o_k_ready;
    // i_k is sampled only on that edge, and ready stays low while a modulus is pending.
    logic transfer;
    logic accept;
    logic at_wrap;

    assign transfer = i_k_valid && (state != S_PEND);
    assign accept   = transfer && (i_k != '0);
    assign at_wrap  = (count == (k_active - ONE));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= S_IDLE;
            count     <= '0;
            k_active  <= K_RESET;
            k_pending <= '0;
            roll_over <= 1'b0;
            k_err     <= 1'b0;
        end else begin
            k_err     <= transfer && (i_k == '0);
            roll_over <= 1'b0;
            case (state)
                S_PEND: begin
                    if (!i_enable) begin
                        k_active <= k_pending;
                        count    <= '0;
                        state    <= S_IDLE;
                    end else if (at_wrap) begin
                        // The wrap completes the old period; the pending modulus starts the next one.
                        count     <= '0;
                        roll_over <= 1'b1;
                        k_active  <= k_pending;
                        state     <= S_RUN;
                    end else begin
                        count <= count + ONE;
                    end
                end
                default: begin
                    if (accept && (state == S_IDLE || !i_enable)) begin
                        // Not counting: load the new modulus immediately and restart from zero.
                        k_active <= i_k;
                        count    <= '0;
                        state    <= i_enable ? S_RUN : S_IDLE;
                    end else begin
                        if (i_enable) begin
                            if (at_wrap) begin
                                count     <= '0;
                                roll_over <= 1'b1;
                            end else begin
                                count <= count + ONE;
                            end
                        end
                        if (accept) begin
                            k_pending <= i_k;
                            state     <= S_PEND;
                        end else begin
                            state <= i_enable ? S_RUN : S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign o_k_ready   = (state != S_PEND);
    assign o_k_err     = k_err;
    assign o_count     = count;
    assign o_roll_over = roll_over;

endmodule

// File: tb/tb_rollover_counter.sv
// Self-checking bench for rollover_counter: expected {ready, err, roll, count} tuples are
// queued as stimulus is driven and compared one edge later.
module tb_rollover_counter;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         enable;
    logic         k_valid;
    logic [W-1:0] k;
    logic         k_ready;
    logic         k_err;
    logic [W-1:0] count;
    logic         roll_over;

    logic [W+2:0] exp_q[$];
    int           checks;
    int           passed;

    rollover_counter #(.WIDTH(W), .DEFAULT_K(3)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_enable    (enable),
        .i_k_valid   (k_valid),
        .i_k         (k),
        .o_k_ready   (k_ready),
        .o_k_err     (k_err),
        .o_count     (count),
        .o_roll_over (roll_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W+2:0] pack(input logic rdy, input logic err, input logic roll,
                                          input int cnt);
        return {rdy, err, roll, W'(cnt)};
    endfunction

    task automatic do_reset(input logic en);
        rst     = 1'b1;
        k_valid = 1'b0;
        k       = '0;
        enable  = en;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [W+2:0] got, exp;
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int n = 1; n <= 2; n++) begin
            exp_q.push_back(pack(1, 0, 0, n));
            @(posedge clk); #1;
            got = {k_ready, k_err, roll_over, count};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) $display("FAIL reset_pre step %0d: got %h expected %h", n, got, exp);
            else passed++;
        end
        #3 rst = 1'b1;
        for (int n = 0; n < 2; n++) begin
            exp_q.push_back(pack(1, 0, 0, 0));
            if (n == 0) #1;
            else begin @(posedge clk); #1; end
            got = {k_ready, k_err, roll_over, count};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) $display("FAIL reset_async step %0d: got %h expected %h", n, got, exp);
            else passed++;
        end
    endtask

    task automatic test_count();
        logic [W+2:0] got, exp;
        do_reset(1'b1);
        for (int n = 1; n <= 12; n++) begin
            exp_q.push_back(pack(1, 0, (n % 3) == 0, n % 3));
            @(posedge clk); #1;
            got = {k_ready, k_err, roll_over, count};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) $display("FAIL count_k3 edge %0d: got %h expected %h", n, got, exp);
            else passed++;
        end
    endtask

    task automatic test_k_update();
        logic [W+2:0] got, exp;
        int cnt_t[9]  = '{1, 2, 0, 1, 2, 3, 4, 0, 1};
        int roll_t[9] = '{0, 0, 1, 0, 0, 0, 0, 1, 0};
        int rdy_t[9]  = '{1, 0, 1, 1, 1, 1, 1, 1, 1};
        do_reset(1'b1);
        for (int i = 0; i < 9; i++) begin
            k_valid = (i == 1);
            k       = (i == 1) ? W'(5) : W'($urandom_range(1, 200));
            exp_q.push_back(pack(rdy_t[i][0], 0, roll_t[i][0], cnt_t[i]));
            @(posedge clk); #1;
            got = {k_ready, k_err, roll_over, count};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) $display("FAIL k_update edge %0d: got %h expected %h", i, got, exp);
            else passed++;
        end
        k_valid = 1'b0;
    endtask

    task automatic test_k_zero();
        logic [W+2:0] got, exp;
        int cnt_t[5]  = '{1, 2, 0, 1, 2};
        int roll_t[5] = '{0, 0, 1, 0, 0};
        int err_t[5]  = '{0, 1, 0, 0, 0};
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) begin
            k_valid = (i == 1);
            k       = '0;
            exp_q.push_back(pack(1, err_t[i][0], roll_t[i][0], cnt_t[i]));
            @(posedge clk); #1;
            got = {k_ready, k_err, roll_over, count};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) $display("FAIL k_zero edge %0d: got %h expected %h", i, got, exp);
            else passed++;
        end
        k_valid = 1'b0;
    endtask

    task automatic test_enable_hold();
        logic [W+2:0] got, exp;
        int hold;
        int total;
        hold  = $urandom_range(4, 6);
        total = hold + 4;
        do_reset(1'b1);
        for (int i = 0; i < total; i++) begin
            enable = !(i >= 2 && i < 2 + hold);
            if (i < 2)              exp_q.push_back(pack(1, 0, 0, i + 1));
            else if (i < 2 + hold)  exp_q.push_back(pack(1, 0, 0, 2));
            else if (i == 2 + hold) exp_q.push_back(pack(1, 0, 1, 0));
            else                    exp_q.push_back(pack(1, 0, 0, 1));
            @(posedge clk); #1;
            got = {k_ready, k_err, roll_over, count};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) $display("FAIL enable_hold edge %0d: got %h expected %h", i, got, exp);
            else passed++;
        end
    endtask

    task automatic test_k_one();
        logic [W+2:0] got, exp;
        int cnt_t[12]  = '{0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0, 1};
        int roll_t[12] = '{0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 0};
        int rdy_t[12]  = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
        do_reset(1'b1);
        for (int i = 0; i < 12; i++) begin
            k_valid = (i == 0) || (i == 5);
            k       = (i == 0) ? W'(1) : W'(4);
            exp_q.push_back(pack(rdy_t[i][0], 0, roll_t[i][0], cnt_t[i]));
            @(posedge clk); #1;
            got = {k_ready, k_err, roll_over, count};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) $display("FAIL k_one edge %0d: got %h expected %h", i, got, exp);
            else passed++;
        end
        k_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [W+2:0] got, exp;
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) begin
            k_valid = (i == 2);
            k       = W'(7);
            exp_q.push_back((i == 2) ? pack(0, 0, 1, 0) : pack(1, 0, 0, i + 1));
            @(posedge clk); #1;
            got = {k_ready, k_err, roll_over, count};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) $display("FAIL reset_mid_pre edge %0d: got %h expected %h", i, got, exp);
            else passed++;
        end
        k_valid = 1'b0;
        #3 rst = 1'b1;
        exp_q.push_back(pack(1, 0, 0, 0));
        #1;
        got = {k_ready, k_err, roll_over, count};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) $display("FAIL reset_mid_async: got %h expected %h", got, exp);
        else passed++;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            exp_q.push_back(pack(1, 0, (n % 3) == 0, n % 3));
            @(posedge clk); #1;
            got = {k_ready, k_err, roll_over, count};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) $display("FAIL reset_mid_post edge %0d: got %h expected %h", n, got, exp);
            else passed++;
        end
    endtask

    initial begin
        checks  = 0;
        passed  = 0;
        rst     = 1'b1;
        enable  = 1'b0;
        k_valid = 1'b0;
        k       = '0;
        test_reset();
        test_count();
        test_k_update();
        test_k_zero();
        test_enable_hold();
        test_k_one();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
